add3_3_arb: RTL and testbench

Round-robin arbiter and pipeline sequencer that shares one `add3_3` 3x3 window adder (9-input sum, divided by 16, 5-cycle enabled latency) between `pNUM_REQ` requesters. It sits between the per-channel window generators and the single adder instance. It drives the adder's `ien` as a global pipeline-advance signal and tracks valid and requester-ID alongside the adder pipeline, so each result returns tagged with its owner. Downstream backpressure stalls the whole adder pipeline losslessly.

---
 rtl/add3_3_pkg.sv | 16 +
 rtl/add3_3_arb_rr.sv | 38 +++
 rtl/add3_3_arb.sv | 81 ++++++++
 tb/tb_add3_3_arb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add3_3_pkg.sv
// Shared constants and helpers for the add3_3 arbiter slice.
// Exports ADD3_3_LAT, WIN_N and id_w().
package add3_3_pkg;

   // Enabled-cycle latency of the add3_3 window adder.
   localparam int ADD3_3_LAT = 5;

   // Elements per 3x3 window.
   localparam int WIN_N = 9;

   // Width of a requester index, never below one bit.
   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add3_3_arb_rr.sv
// Combinational round-robin picker: first set ireq at or above iptr, wrapping.
// Ports: ireq, ien, iptr in; ogrant (one-hot or zero), ogrant_idx out.
module rr_arbiter
   import add3_3_pkg::*;
#(
   parameter int pN = 4,
   localparam int IW = id_w(pN)
) (
   input  logic [pN-1:0] ireq,
   input  logic          ien,
   input  logic [IW-1:0] iptr,
   output logic [pN-1:0] ogrant,
   output logic [IW-1:0] ogrant_idx
);

   int            k;
   logic [IW-1:0] idx;
   logic          hit;

   always_comb begin
      ogrant     = '0;
      ogrant_idx = '0;
      hit        = 1'b0;
      k          = 0;
      idx        = '0;
      for (int i = 0; i < pN; i++) begin
         k = int'(iptr) + i;
         if (k >= pN) k = k - pN;
         idx = IW'(k);
         if (ien && !hit && ireq[idx]) begin
            hit             = 1'b1;
            ogrant[idx]     = 1'b1;
            ogrant_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/add3_3_arb.sv
// Shares one add3_3 window adder among pNUM_REQ requesters with tagged results.
// Ports: iclk/irst_n; ireq_* / oreq_ready; oadd_* / iadd_data; ores_* / ires_ready; obusy.
module add3_3_arb
   import add3_3_pkg::*;
#(
   parameter int pDATA_W  = 8,
   parameter int pNUM_REQ = 4,
   parameter int pADD_LAT = ADD3_3_LAT,
   localparam int IW = id_w(pNUM_REQ)
) (
   input  logic                                           iclk,
   input  logic                                           irst_n,
   input  logic [pNUM_REQ-1:0]                            ireq_valid,
   input  logic [pNUM_REQ-1:0][WIN_N-1:0][pDATA_W-1:0]   ireq_data,
   output logic [pNUM_REQ-1:0]                            oreq_ready,
   output logic                                           oadd_en,
   output logic [WIN_N-1:0][pDATA_W-1:0]                  oadd_data,
   input  logic [2*pDATA_W-1:0]                           iadd_data,
   output logic                                           ores_valid,
   output logic [IW-1:0]                                  ores_id,
   output logic [2*pDATA_W-1:0]                           ores_data,
   input  logic                                           ires_ready,
   output logic                                           obusy
);

   typedef logic [WIN_N-1:0][pDATA_W-1:0] window_t;

   logic [pADD_LAT-1:0]         vld;
   logic [pADD_LAT-1:0][IW-1:0] id;
   logic [IW-1:0]               rr_ptr;
   logic [pNUM_REQ-1:0]         grant;
   logic [IW-1:0]               gidx;
   logic                        adv;
   logic                        take;
   window_t                     win;

   // A result parked at the adder output with no taker freezes
   // the adder, the tag pipeline and the grant together.
   assign adv = !(vld[pADD_LAT-1] && !ires_ready);

   rr_arbiter #(
      .pN(pNUM_REQ)
   ) u_rr (
      .ireq      (ireq_valid),
      .ien       (adv),
      .iptr      (rr_ptr),
      .ogrant    (grant),
      .ogrant_idx(gidx)
   );

   assign take = |grant;

   // Bubbles feed zeros; their adder output is masked by vld.
   always_comb begin
      win = '0;
      if (take) win = ireq_data[gidx];
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         vld    <= '0;
         id     <= '0;
         rr_ptr <= '0;
      end else if (adv) begin
         vld <= {vld[pADD_LAT-2:0], take};
         id  <= {id[pADD_LAT-2:0], gidx};
         if (take) begin
            rr_ptr <= (gidx == IW'(pNUM_REQ - 1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   assign oreq_ready = grant;
   assign oadd_en    = adv;
   assign oadd_data  = win;
   assign ores_valid = vld[pADD_LAT-1];
   assign ores_id    = id[pADD_LAT-1];
   assign ores_data  = iadd_data;
   assign obusy      = |vld;

endmodule

// File: tb/tb_add3_3_arb.sv
// Directed bench for add3_3_arb with a behavioural 5-stage add3_3 model.
// Prints one summary line of vectors applied and miscompares.
module tb_add3_3_arb;

   logic                 clk;
   logic                 rst_n;
   logic [3:0]           req_valid;
   logic [3:0][8:0][7:0] req_data;
   logic [3:0]           req_ready;
   logic                 add_en;
   logic [8:0][7:0]      add_data;
   logic [15:0]          add_res;
   logic                 res_valid;
   logic [1:0]           res_id;
   logic [15:0]          res_data;
   logic                 res_ready;
   logic                 busy;

   int vecs = 0;
   int errs = 0;

   add3_3_arb #(
      .pDATA_W (8),
      .pNUM_REQ(4),
      .pADD_LAT(5)
   ) dut (
      .iclk      (clk),
      .irst_n    (rst_n),
      .ireq_valid(req_valid),
      .ireq_data (req_data),
      .oreq_ready(req_ready),
      .oadd_en   (add_en),
      .oadd_data (add_data),
      .iadd_data (add_res),
      .ores_valid(res_valid),
      .ores_id   (res_id),
      .ores_data (res_data),
      .ires_ready(res_ready),
      .obusy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural add3_3: floor(sum/16), five enabled stages, no reset.
   logic [15:0] apipe [5];

   function automatic logic [15:0] sum9(input logic [8:0][7:0] w);
      int s;
      s = 0;
      for (int i = 0; i < 9; i++) s += int'(w[i]);
      return 16'(s / 16);
   endfunction

   always @(posedge clk) begin
      if (add_en) begin
         apipe[0] <= sum9(add_data);
         for (int i = 1; i < 5; i++) apipe[i] <= apipe[i-1];
      end
   end

   assign add_res = apipe[4];

   // Requester protocol: a pending request may not vanish before grant.
   logic [3:0] pend;
   logic       prev_rst_n;

   always @(posedge clk) begin
      if (rst_n && prev_rst_n) begin
         for (int r = 0; r < 4; r++) begin
            assert (!(pend[r] && !req_valid[r]))
               else $error("protocol: requester %0d dropped before grant", r);
         end
      end
      pend       <= rst_n ? (req_valid & ~req_ready) : 4'h0;
      prev_rst_n <= rst_n;
   end

   task automatic reset_dut();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 4'h0;
      res_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      vecs++;
      if ({res_valid, res_id, busy, add_en} !== 5'b00001) begin
         errs++;
         $display("FAIL reset_outs got v=%b id=%0d busy=%b en=%b want 0 0 0 1",
                  res_valid, res_id, busy, add_en);
      end
      vecs++;
      if (req_ready !== 4'h0) begin
         errs++;
         $display("FAIL reset_ready_idle got %b want 0000", req_ready);
      end
      req_valid = 4'b0100;
      #1;
      vecs++;
      if (req_ready !== 4'b0100) begin
         errs++;
         $display("FAIL reset_ready_req got %b want 0100", req_ready);
      end
      req_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      req_data[0] = {9{8'd16}};
      req_valid   = 4'b0001;
      #1;
      vecs++;
      if ({req_ready, add_en} !== 5'b00011) begin
         errs++;
         $display("FAIL single_grant got rdy=%b en=%b want 0001 1", req_ready, add_en);
      end
      vecs++;
      if (add_data !== {9{8'd16}}) begin
         errs++;
         $display("FAIL single_mux got %h want %h", add_data, {9{8'd16}});
      end
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 4'h0;
         #1;
         if (c < 5) begin
            vecs++;
            if ({res_valid, busy} !== 2'b01) begin
               errs++;
               $display("FAIL single_wait[%0d] got v=%b busy=%b want 0 1", c, res_valid, busy);
            end
         end else if (c == 5) begin
            vecs++;
            if ({res_valid, res_id, res_data, busy} !== {1'b1, 2'd0, 16'd9, 1'b1}) begin
               errs++;
               $display("FAIL single_res got v=%b id=%0d d=%0d busy=%b want 1 0 9 1",
                        res_valid, res_id, res_data, busy);
            end
         end else begin
            vecs++;
            if ({res_valid, busy} !== 2'b00) begin
               errs++;
               $display("FAIL single_drain got v=%b busy=%b want 0 0", res_valid, busy);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_fairness();
      logic [3:0] eg;
      int         j;
      reset_dut();
      for (int r = 0; r < 4; r++) req_data[r] = {9{8'(16 * (r + 1))}};
      for (int k = 0; k < 12; k++) begin
         case (k)
            0, 1, 2: req_valid = 4'b1111;
            3:       req_valid = 4'b1011;
            4:       req_valid = 4'b0011;
            5:       req_valid = 4'b0010;
            default: req_valid = 4'b0000;
         endcase
         #1;
         eg = (k < 6) ? 4'(1 << (k % 4)) : 4'h0;
         vecs++;
         if (req_ready !== eg) begin
            errs++;
            $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, eg);
         end
         if (k >= 5 && k < 11) begin
            j = (k - 5) % 4;
            vecs++;
            if ({res_valid, res_id, res_data} !== {1'b1, 2'(j), 16'(9 * (j + 1))}) begin
               errs++;
               $display("FAIL rr_res[%0d] got v=%b id=%0d d=%0d want 1 %0d %0d",
                        k, res_valid, res_id, res_data, j, 9 * (j + 1));
            end
         end else begin
            vecs++;
            if (res_valid !== 1'b0) begin
               errs++;
               $display("FAIL rr_idle[%0d] got v=%b want 0", k, res_valid);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]  eg;
      logic [18:0] er;
      req_data[0] = {9{8'd32}};
      req_data[1] = {9{8'd48}};
      req_data[3] = {9{8'd64}};
      for (int k = 0; k < 14; k++) begin
         case (k)
            0:          req_valid = 4'b0011;
            1:          req_valid = 4'b0010;
            5, 6, 7, 8: req_valid = 4'b1000;
            default:    req_valid = 4'b0000;
         endcase
         res_ready = !(k >= 5 && k <= 7);
         #1;
         case (k)
            0:       eg = 4'b0001;
            1:       eg = 4'b0010;
            8:       eg = 4'b1000;
            default: eg = 4'b0000;
         endcase
         vecs++;
         if ({req_ready, add_en} !== {eg, !(k >= 5 && k <= 7)}) begin
            errs++;
            $display("FAIL bp_grant[%0d] got rdy=%b en=%b want %b %b",
                     k, req_ready, add_en, eg, !(k >= 5 && k <= 7));
         end
         case (k)
            5, 6, 7, 8: er = {1'b1, 2'd0, 16'd18};
            9:          er = {1'b1, 2'd1, 16'd27};
            13:         er = {1'b1, 2'd3, 16'd36};
            default:    er = '0;
         endcase
         if (er[18]) begin
            vecs++;
            if ({res_valid, res_id, res_data} !== er) begin
               errs++;
               $display("FAIL bp_res[%0d] got v=%b id=%0d d=%0d want 1 %0d %0d",
                        k, res_valid, res_id, res_data, er[17:16], er[15:0]);
            end
         end else begin
            vecs++;
            if (res_valid !== 1'b0) begin
               errs++;
               $display("FAIL bp_idle[%0d] got v=%b want 0", k, res_valid);
            end
         end
         @(negedge clk);
      end
      res_ready = 1'b1;
   endtask

   task automatic test_max();
      req_data[1] = {9{8'd255}};
      for (int k = 0; k < 7; k++) begin
         req_valid = (k == 0) ? 4'b0010 : 4'b0000;
         #1;
         if (k == 0) begin
            vecs++;
            if (req_ready !== 4'b0010) begin
               errs++;
               $display("FAIL max_grant got %b want 0010", req_ready);
            end
         end else if (k == 5) begin
            vecs++;
            if ({res_valid, res_id, res_data} !== {1'b1, 2'd1, 16'd143}) begin
               errs++;
               $display("FAIL max_res got v=%b id=%0d d=%0d want 1 1 143",
                        res_valid, res_id, res_data);
            end
         end else begin
            vecs++;
            if (res_valid !== 1'b0) begin
               errs++;
               $display("FAIL max_idle[%0d] got v=%b want 0", k, res_valid);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_sparse();
      req_data[1] = {9{8'd8}};
      req_data[3] = {9{8'd100}};
      for (int k = 0; k < 8; k++) begin
         case (k)
            0:       req_valid = 4'b1010;
            1:       req_valid = 4'b0010;
            default: req_valid = 4'b0000;
         endcase
         #1;
         if (k == 0 || k == 1) begin
            vecs++;
            if (req_ready !== ((k == 0) ? 4'b1000 : 4'b0010)) begin
               errs++;
               $display("FAIL sparse_grant[%0d] got %b want %b",
                        k, req_ready, (k == 0) ? 4'b1000 : 4'b0010);
            end
         end
         if (k == 2) begin
            vecs++;
            if ({req_ready, add_data} !== '0) begin
               errs++;
               $display("FAIL sparse_bubble got rdy=%b data=%h want 0 0", req_ready, add_data);
            end
         end
         if (k == 5) begin
            vecs++;
            if ({res_valid, res_id, res_data} !== {1'b1, 2'd3, 16'd56}) begin
               errs++;
               $display("FAIL sparse_res3 got v=%b id=%0d d=%0d want 1 3 56",
                        res_valid, res_id, res_data);
            end
         end else if (k == 6) begin
            vecs++;
            if ({res_valid, res_id, res_data} !== {1'b1, 2'd1, 16'd4}) begin
               errs++;
               $display("FAIL sparse_res1 got v=%b id=%0d d=%0d want 1 1 4",
                        res_valid, res_id, res_data);
            end
         end else if (k >= 2) begin
            vecs++;
            if (res_valid !== 1'b0) begin
               errs++;
               $display("FAIL sparse_idle[%0d] got v=%b want 0", k, res_valid);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] eg;
      req_data[0] = {9{8'd16}};
      req_data[1] = {9{8'd16}};
      req_data[2] = {9{8'd16}};
      req_data[3] = {9{8'd32}};
      for (int k = 0; k < 17; k++) begin
         case (k)
            0:       req_valid = 4'b0100;
            1:       req_valid = 4'b0001;
            2:       req_valid = 4'b0010;
            10:      req_valid = 4'b1010;
            11:      req_valid = 4'b1000;
            default: req_valid = 4'b0000;
         endcase
         if (k == 4) rst_n = 1'b1;
         #1;
         case (k)
            0:       eg = 4'b0100;
            1:       eg = 4'b0001;
            2:       eg = 4'b0010;
            10:      eg = 4'b0010;
            11:      eg = 4'b1000;
            default: eg = 4'b0000;
         endcase
         if (k <= 2 || k == 10 || k == 11) begin
            vecs++;
            if (req_ready !== eg) begin
               errs++;
               $display("FAIL rmid_grant[%0d] got %b want %b", k, req_ready, eg);
            end
         end
         if (k == 3) begin
            vecs++;
            if (busy !== 1'b1) begin
               errs++;
               $display("FAIL rmid_busy got %b want 1", busy);
            end
            rst_n = 1'b0;
         end else if (k == 15) begin
            vecs++;
            if ({res_valid, res_id, res_data} !== {1'b1, 2'd1, 16'd9}) begin
               errs++;
               $display("FAIL rmid_res1 got v=%b id=%0d d=%0d want 1 1 9",
                        res_valid, res_id, res_data);
            end
         end else if (k == 16) begin
            vecs++;
            if ({res_valid, res_id, res_data} !== {1'b1, 2'd3, 16'd18}) begin
               errs++;
               $display("FAIL rmid_res3 got v=%b id=%0d d=%0d want 1 3 18",
                        res_valid, res_id, res_data);
            end
         end else if (k >= 4 && k <= 9) begin
            vecs++;
            if ({res_valid, busy} !== 2'b00) begin
               errs++;
               $display("FAIL rmid_drop[%0d] got v=%b busy=%b want 0 0", k, res_valid, busy);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 4'h0;
      req_data   = '0;
      res_ready  = 1'b1;
      pend       = 4'h0;
      prev_rst_n = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_max();
      test_sparse();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
